shift_reg_u: RTL and testbench

Parametrised universal shift register for the MUL datapath, replacing fixed 16-bit load-only registers where operands must also be shifted. It holds a WIDTH-bit word, loads it in parallel in one cycle, and performs a multi-cycle shift/rotate of a requested amount, one bit position per clock. A start/busy/done handshake lets the controller FSM sequence it alongside adders and counters.

---
 rtl/shift_reg_pkg.sv | 21 ++
 rtl/shift_step.sv | 28 ++
 rtl/shift_reg_u.sv | 81 ++++++++
 tb/tb_shift_reg_u.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shift_reg_pkg : mode and state encodings for the universal shift register |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROL = 2'b11
  } shift_mode_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_e;

endpackage : shift_reg_pkg
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shift_step : combinational single-bit shift/rotate unit                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module shift_step
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  shift_mode_e      i_mode,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  always_comb begin
    o_dout = i_din;
    case (i_mode)
      MODE_SLL: o_dout = {i_din[WIDTH-2:0], 1'b0};
      MODE_SRL: o_dout = {1'b0, i_din[WIDTH-1:1]};
      MODE_SRA: o_dout = {i_din[WIDTH-1], i_din[WIDTH-1:1]};
      MODE_ROL: o_dout = {i_din[WIDTH-2:0], i_din[WIDTH-1]};
      default:  o_dout = i_din;
    endcase
  end

endmodule : shift_step
`default_nettype wire

// File: rtl/shift_reg_u.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shift_reg_u : loadable register with multi-cycle shift/rotate, 1 bit/clk |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module shift_reg_u
  import shift_reg_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             ld,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done
);

  shift_state_e     r_state;
  shift_mode_e      r_mode;
  logic [AMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_done;
  logic [WIDTH-1:0] w_step;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_mode (r_mode),
    .i_din  (r_data),
    .o_dout (w_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_SLL;
      r_cnt   <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ld) begin
            r_data <= din;
          end else if (start) begin
            // A zero-length request completes immediately without entering SHIFT
            if (amt == '0) begin
              r_done <= 1'b1;
            end else begin
              r_mode  <= shift_mode_e'(mode);
              r_cnt   <= amt;
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          r_data <= w_step;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == AMT_W'(1)) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dout = r_data;
  assign busy = (r_state == ST_SHIFT);
  assign done = r_done;

endmodule : shift_reg_u
`default_nettype wire

// File: tb/tb_shift_reg_u.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_shift_reg_u : directed table-driven bench for shift_reg_u             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_shift_reg_u;
  import shift_reg_pkg::*;

  localparam int WIDTH = 16;
  localparam int AMT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             ld;
  logic             start;
  logic [1:0]       mode;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] dout;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  shift_reg_u #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .ld    (ld),
    .start (start),
    .mode  (mode),
    .amt   (amt),
    .dout  (dout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] din;
    logic [1:0]       mode;
    int               amt;
    logic [WIDTH-1:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [WIDTH-1:0] d);
    ld = 1'b1; din = d;
    tick();
    ld = 1'b0;
  endtask

  // Load, launch one operation, then watch busy/done for amt+3 cycles.
  task automatic run_op(input string name, input vec_t v);
    int busy_cnt, done_cnt, done_idx;
    load(v.din);
    start = 1'b1; mode = v.mode; amt = AMT_W'(v.amt);
    tick();
    start = 1'b0; mode = 2'b00; amt = '0;
    busy_cnt = 0; done_cnt = 0; done_idx = -1;
    for (int i = 0; i < v.amt + 3; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_idx = i;
      end
      tick();
    end
    check({name, " dout"}, int'(dout), int'(v.exp));
    check({name, " busy_cycles"}, busy_cnt, v.amt);
    check({name, " done_pulses"}, done_cnt, 1);
    check({name, " done_cycle"}, done_idx, v.amt);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{16'h8001, MODE_SRA, 3,  16'hF000};
    vecs[1] = '{16'h8001, MODE_ROL, 17, 16'h0003};
    vecs[2] = '{16'hFFFF, MODE_SLL, 16, 16'h0000};
    vecs[3] = '{16'h8001, MODE_SRL, 1,  16'h4000};
    vecs[4] = '{16'h1234, MODE_ROL, 0,  16'h1234};
    vecs[5] = '{16'h8000, MODE_SRA, 20, 16'hFFFF};
    vecs[6] = '{16'h00F0, MODE_SLL, 4,  16'h0F00};
    vecs[7] = '{16'hF00F, MODE_SRL, 31, 16'h0000};
    vecs[8] = '{16'h8001, MODE_ROL, 16, 16'h8001};

    rst = 1'b1; ld = 1'b0; start = 1'b0; din = '0; mode = '0; amt = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset dout", int'(dout), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);

    load(16'hA5C3);
    check("load dout", int'(dout), 16'hA5C3);
    check("load busy", int'(busy), 0);
    check("load done", int'(done), 0);

    for (int i = 0; i < 9; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // ld and start together in IDLE: load wins, no operation, no done
    ld = 1'b1; start = 1'b1; din = 16'h5555; mode = MODE_SLL; amt = AMT_W'(3);
    tick();
    ld = 1'b0; start = 1'b0;
    check("ldstart dout", int'(dout), 16'h5555);
    check("ldstart busy", int'(busy), 0);
    check("ldstart done", int'(done), 0);
    tick();
    check("ldstart done2", int'(done), 0);
    check("ldstart dout2", int'(dout), 16'h5555);

    // ld/start while busy are ignored
    load(16'h0F0F);
    start = 1'b1; mode = MODE_SLL; amt = AMT_W'(5);
    tick();
    start = 1'b0;
    tick(); tick();
    ld = 1'b1; din = 16'h1234; start = 1'b1; mode = MODE_SRL; amt = AMT_W'(1);
    tick();
    ld = 1'b0; start = 1'b0; mode = '0; amt = '0;
    begin
      int guard = 0;
      while (!done && guard < 10) begin
        tick();
        guard++;
      end
      check("busyign timeout", guard < 10 ? 1 : 0, 1);
    end
    check("busyign dout", int'(dout), 16'hE1E0);
    tick();
    check("busyign idle", int'(busy), 0);

    // reset mid-shift abandons the operation
    load(16'hFFFF);
    start = 1'b1; mode = MODE_SLL; amt = AMT_W'(10);
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst dout", int'(dout), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst done", int'(done), 0);
    for (int i = 0; i < 12; i++) begin
      if (done) check("midrst late_done", int'(done), 0);
      tick();
    end
    run_op("postrst", '{16'h0003, MODE_SLL, 2, 16'h000C});

    // new start accepted in the done cycle
    load(16'h0001);
    start = 1'b1; mode = MODE_SLL; amt = AMT_W'(1);
    tick();
    start = 1'b0;
    tick();
    check("b2b done", int'(done), 1);
    start = 1'b1; mode = MODE_SLL; amt = AMT_W'(2);
    tick();
    start = 1'b0;
    check("b2b busy", int'(busy), 1);
    check("b2b done_low", int'(done), 0);
    tick(); tick();
    check("b2b done2", int'(done), 1);
    check("b2b dout", int'(dout), 16'h0008);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_shift_reg_u
`default_nettype wire
